// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - multi-channel traffic phase controller with ms timing and demand latches
// Optional pedestrian walk phase: define TRAFFIC_PED_WALK_EN to enable it.
module traffic_phase_ctrl #(
  parameter int NCH          = 3,
  parameter int PRESC        = 10,
  parameter int GREEN_MS     = 20000,
  parameter int MIN_GREEN_MS = 5000,
  parameter int YELLOW_MS    = 3000,
  parameter int ALLRED_MS    = 1000,
  parameter int WALK_MS      = 8000,
  parameter int TW           = 16,
  localparam int AW          = $clog2(NCH)
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic           en,
  input  logic [NCH-1:0] demand,
  input  logic           ped_req,
  output logic [NCH-1:0] green,
  output logic [NCH-1:0] yellow,
  output logic [NCH-1:0] red,
  output logic [AW-1:0]  active,
  output logic           walk
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [NCH-1:0] ONE = NCH'(1);

  typedef enum logic [1:0] {
    S_ALL_RED = 2'd0,
    S_GREEN   = 2'd1,
    S_YELLOW  = 2'd2,
    S_WALK    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_nxt;
  logic [TW-1:0]   ms_q, ms_nxt;
  logic [NCH-1:0]  latch_q, latch_d, clr_mask, others;
  logic [AW-1:0]   active_q, active_d, sel_ch;
  logic            tick;
  logic            ped_set;
  logic [2*NCH-1:0] rot_all;
  logic [NCH-1:0]  green_c, yellow_c, red_c;
  logic            walk_c;

`ifdef TRAFFIC_PED_WALK_EN
  logic            ped_q;

  // Pedestrian request latch: collects ped_req, cleared once the walk phase is taken.
  always_ff @(posedge CLK) begin
    if (reset) begin
      ped_q <= 1'b0;
    end else if (en) begin
      ped_q <= (state_d == S_WALK) ? 1'b0 : (ped_q | ped_req);
    end
  end

  assign ped_set = ped_q;
`else
  logic unused_ped;
  assign unused_ped = ped_req;
  assign ped_set    = 1'b0;
`endif

  // Prescaler and saturating ms counter values for the next enabled cycle.
  always_comb begin
    tick    = (pre_q == PW'(PRESC - 1));
    pre_nxt = tick ? '0 : pre_q + PW'(1);
    ms_nxt  = (tick && (ms_q != '1)) ? ms_q + TW'(1) : ms_q;
  end

  // Round-robin scan from active+1 for the first latched demand, defaulting to active+1.
  always_comb begin
    logic [2*NCH-1:0] tmp;
    int off;
    off     = 0;
    tmp     = '0;
    rot_all = {latch_q, latch_q} >> (int'(active_q) + 1);
    for (int k = NCH - 1; k >= 0; k--) begin
      tmp = rot_all >> k;
      if (tmp[0]) off = k;
    end
    sel_ch = AW'((int'(active_q) + 1 + off) % NCH);
  end

  assign others = latch_q & ~(ONE << active_q);

  // Next-state logic: each state ends on the tick that brings ms up to its duration.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    case (state_q)
      S_ALL_RED: begin
        if (ms_nxt == TW'(ALLRED_MS)) begin
          if (ped_set) begin
            state_d = S_WALK;
          end else begin
            state_d  = S_GREEN;
            active_d = sel_ch;
          end
        end
      end
      S_GREEN: begin
        if ((ms_nxt == TW'(GREEN_MS)) ||
            ((ms_nxt >= TW'(MIN_GREEN_MS)) && (|others))) begin
          state_d = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (ms_nxt == TW'(YELLOW_MS)) state_d = S_ALL_RED;
      end
      S_WALK: begin
        if (ms_nxt == TW'(WALK_MS)) state_d = S_ALL_RED;
      end
      default: state_d = S_ALL_RED;
    endcase
  end

  // Demand latches: served channel is cleared on green entry and kept clear while green.
  always_comb begin
    clr_mask = '0;
    if (state_d == S_GREEN) clr_mask = clr_mask | (ONE << active_d);
    if (state_q == S_GREEN) clr_mask = clr_mask | (ONE << active_q);
    latch_d = (latch_q | demand) & ~clr_mask;
  end

  // State register, counters, latches and served channel; everything frozen when en is low.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= S_ALL_RED;
      pre_q    <= '0;
      ms_q     <= '0;
      latch_q  <= '0;
      active_q <= AW'(NCH - 1);
    end else if (en) begin
      state_q  <= state_d;
      active_q <= active_d;
      latch_q  <= latch_d;
      if (state_d != state_q) begin
        pre_q <= '0;
        ms_q  <= '0;
      end else begin
        pre_q <= pre_nxt;
        ms_q  <= ms_nxt;
      end
    end
  end

  // Lamp decode from the current state; exactly one lamp lit per channel.
  always_comb begin
    green_c  = '0;
    yellow_c = '0;
    red_c    = '1;
    walk_c   = 1'b0;
    case (state_q)
      S_GREEN: begin
        green_c = ONE << active_q;
        red_c   = ~(ONE << active_q);
      end
      S_YELLOW: begin
        yellow_c = ONE << active_q;
        red_c    = ~(ONE << active_q);
      end
      S_WALK:  walk_c = 1'b1;
      default: red_c  = '1;
    endcase
  end

  // Registered lamp outputs, one cycle behind the state register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      green  <= '0;
      yellow <= '0;
      red    <= '1;
      walk   <= 1'b0;
    end else if (en) begin
      green  <= green_c;
      yellow <= yellow_c;
      red    <= red_c;
      walk   <= walk_c;
    end
  end

  assign active = active_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - directed self-checking bench for traffic_phase_ctrl
module tb_traffic_phase_ctrl;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [2:0] demand = 3'b000;
  logic       ped_req = 1'b0;
  logic [2:0] green, yellow, red;
  logic [1:0] active;
  logic       walk;
  logic [9:0] pat;

  int checks = 0;
  int errors = 0;

  traffic_phase_ctrl #(
    .NCH(3), .PRESC(2), .GREEN_MS(10), .MIN_GREEN_MS(4),
    .YELLOW_MS(3), .ALLRED_MS(2), .WALK_MS(5), .TW(16)
  ) dut (
    .CLK(CLK), .reset(reset), .en(en), .demand(demand), .ped_req(ped_req),
    .green(green), .yellow(yellow), .red(red), .active(active), .walk(walk)
  );

  always #5 CLK = ~CLK;

  assign pat = {green, yellow, red, walk};

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Number of consecutive samples the lamp pattern holds, starting at the current one.
  task automatic measure(output int len);
    logic [9:0] p;
    p = pat;
    len = 1;
    step();
    while (pat === p && len < 200) begin
      len++;
      step();
    end
    if (len >= 200) begin
      checks++;
      errors++;
      $display("FAIL measure_timeout pattern=%b held %0d cycles", p, len);
    end
  endtask

  task automatic test_reset();
    en = 1'b0;
    do_reset();
    checks++; if (red !== 3'b111)   begin errors++; $display("FAIL reset_red got=%b exp=111", red); end
    checks++; if (green !== 3'b000) begin errors++; $display("FAIL reset_green got=%b exp=000", green); end
    checks++; if (yellow !== 3'b000) begin errors++; $display("FAIL reset_yellow got=%b exp=000", yellow); end
    checks++; if (walk !== 1'b0)    begin errors++; $display("FAIL reset_walk got=%b exp=0", walk); end
    checks++; if (active !== 2'd2)  begin errors++; $display("FAIL reset_active got=%0d exp=2", active); end
    step();
    checks++; if (red !== 3'b111)   begin errors++; $display("FAIL reset_hold_en0 red got=%b exp=111", red); end
  endtask

  task automatic test_idle_rotation();
    int n;
    en = 1'b1;
    do_reset();
    step();
    measure(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL idle_allred_len got=%0d exp=4", n); end
    checks++; if (green !== 3'b001 || red !== 3'b110) begin errors++; $display("FAIL idle_green0 got g=%b r=%b exp g=001 r=110", green, red); end
    checks++; if (active !== 2'd0) begin errors++; $display("FAIL idle_active0 got=%0d exp=0", active); end
    measure(n);
    checks++; if (n !== 20) begin errors++; $display("FAIL idle_green_len got=%0d exp=20", n); end
    checks++; if (yellow !== 3'b001 || green !== 3'b000) begin errors++; $display("FAIL idle_yellow0 got y=%b g=%b exp y=001 g=000", yellow, green); end
    measure(n);
    checks++; if (n !== 6) begin errors++; $display("FAIL idle_yellow_len got=%0d exp=6", n); end
    checks++; if (red !== 3'b111) begin errors++; $display("FAIL idle_allred2 got=%b exp=111", red); end
    measure(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL idle_allred2_len got=%0d exp=4", n); end
    checks++; if (green !== 3'b010 || red !== 3'b101) begin errors++; $display("FAIL idle_green1 got g=%b r=%b exp g=010 r=101", green, red); end
  endtask

  task automatic test_demand_skip();
    int n;
    en = 1'b1;
    do_reset();
    step();
    measure(n);
    checks++; if (green !== 3'b001) begin errors++; $display("FAIL skip_green0 got=%b exp=001", green); end
    step();
    demand = 3'b100;
    step();
    demand = 3'b000;
    measure(n);
    n = n + 2;
    checks++; if (n !== 8) begin errors++; $display("FAIL skip_min_green_len got=%0d exp=8", n); end
    checks++; if (yellow !== 3'b001) begin errors++; $display("FAIL skip_yellow0 got=%b exp=001", yellow); end
    measure(n);
    measure(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL skip_allred_len got=%0d exp=4", n); end
    checks++; if (green !== 3'b100 || active !== 2'd2) begin errors++; $display("FAIL skip_green2 got g=%b a=%0d exp g=100 a=2", green, active); end
    measure(n);
    checks++; if (n !== 20) begin errors++; $display("FAIL skip_green2_len got=%0d exp=20", n); end
    measure(n);
    measure(n);
    checks++; if (green !== 3'b001 || active !== 2'd0) begin errors++; $display("FAIL skip_wrap_green0 got g=%b a=%0d exp g=001 a=0", green, active); end
  endtask

  task automatic test_freeze();
    int n;
    logic [9:0] p;
    logic [1:0] a;
    en = 1'b1;
    do_reset();
    step();
    measure(n);
    measure(n);
    checks++; if (yellow !== 3'b001) begin errors++; $display("FAIL freeze_yellow0 got=%b exp=001", yellow); end
    step();
    step();
    en = 1'b0;
    demand = 3'b100;
    p = pat;
    a = active;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (pat !== p || active !== a) begin
        errors++;
        $display("FAIL freeze_hold cycle=%0d got pat=%b a=%0d exp pat=%b a=%0d", i, pat, active, p, a);
      end
    end
    demand = 3'b000;
    en = 1'b1;
    step();
    measure(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL freeze_yellow_remaining got=%0d exp=3", n); end
    measure(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL freeze_allred_len got=%0d exp=4", n); end
    checks++; if (green !== 3'b010) begin errors++; $display("FAIL freeze_next_green1 got=%b exp=010", green); end
  endtask

  task automatic test_reset_mid_green();
    int n;
    en = 1'b1;
    do_reset();
    step();
    measure(n);
    measure(n);
    measure(n);
    measure(n);
    checks++; if (green !== 3'b010) begin errors++; $display("FAIL midrst_green1 got=%b exp=010", green); end
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    step();
    checks++; if (red !== 3'b111 || green !== 3'b000 || yellow !== 3'b000) begin errors++; $display("FAIL midrst_allred got r=%b g=%b y=%b exp r=111 g=000 y=000", red, green, yellow); end
    checks++; if (active !== 2'd2) begin errors++; $display("FAIL midrst_active got=%0d exp=2", active); end
    reset = 1'b0;
    step();
    measure(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL midrst_allred_len got=%0d exp=4", n); end
    checks++; if (green !== 3'b001) begin errors++; $display("FAIL midrst_green0 got=%b exp=001", green); end
  endtask

  task automatic test_ped();
    int n;
    en = 1'b1;
    do_reset();
    step();
    measure(n);
    step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    measure(n);
    n = n + 2;
    checks++; if (n !== 20) begin errors++; $display("FAIL ped_green_len got=%0d exp=20", n); end
    measure(n);
    checks++; if (n !== 6) begin errors++; $display("FAIL ped_yellow_len got=%0d exp=6", n); end
    measure(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL ped_allred_len got=%0d exp=4", n); end
`ifdef TRAFFIC_PED_WALK_EN
    checks++; if (walk !== 1'b1 || red !== 3'b111) begin errors++; $display("FAIL ped_walk got w=%b r=%b exp w=1 r=111", walk, red); end
    measure(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL ped_walk_len got=%0d exp=10", n); end
    measure(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL ped_allred2_len got=%0d exp=4", n); end
`else
    checks++; if (walk !== 1'b0) begin errors++; $display("FAIL ped_walk_off got=%b exp=0", walk); end
`endif
    checks++; if (green !== 3'b010 || walk !== 1'b0) begin errors++; $display("FAIL ped_green1 got g=%b w=%b exp g=010 w=0", green, walk); end
  endtask

  initial begin
    test_reset();
    test_idle_rotation();
    test_demand_skip();
    test_freeze();
    test_reset_mid_green();
    test_ped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 3: number of vehicle channels, range 2..8.
REQ-002 SHALL have parameter PRESC, default 10: enabled CLK cycles per ms tick, which is 1 ms at 10 kHz.
REQ-003 SHALL have parameters GREEN_MS, MIN_GREEN_MS, YELLOW_MS, ALLRED_MS and WALK_MS, defaults 20000, 5000, 3000, 1000 and 8000: state durations in ms, each >=1.
REQ-004 SHALL have parameter TW, default 16: ms counter width; all duration parameters SHALL be < 2^TW.
REQ-005 SHALL have port CLK, input, 1 bit: clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port en, input, 1 bit: run enable; when low, all state is frozen.
REQ-008 SHALL have port demand, input, NCH bits: per-channel sensor or button request, level-sampled.
REQ-009 SHALL have port ped_req, input, 1 bit: pedestrian request.
REQ-010 SHALL have ports green, yellow and red, outputs, NCH bits each: lamp drives, registered.
REQ-011 SHALL have port active, output, clog2(NCH) bits: index of the channel last or currently served.
REQ-012 SHALL have port walk, output, 1 bit: pedestrian green, registered.

Function
REQ-013 SHALL implement FSM states ALL_RED, GREEN, YELLOW and WALK.
REQ-014 SHALL run a prescaler that pulses a ms tick every PRESC enabled cycles, and a TW-bit ms counter that increments on each tick and saturates at all-ones.
REQ-015 SHALL clear both prescaler and ms counter on every state entry, so each state lasts exactly DUR*PRESC enabled cycles.
REQ-016 SHALL keep one latched demand bit per channel: set while demand[i]=1, cleared on entry to GREEN of channel i, and held clear while channel i is green.
REQ-017 SHALL, in ALL_RED when ms = ALLRED_MS, select the next channel by scanning (active+1) mod NCH upward with wrap for the first latched demand bit; if no bit is latched it SHALL take (active+1) mod NCH; then load active and go to GREEN.
REQ-018 SHALL leave GREEN for YELLOW when ms = GREEN_MS, or when ms >= MIN_GREEN_MS and any other channel's latch is set.
REQ-019 SHALL leave YELLOW for ALL_RED when ms = YELLOW_MS.
REQ-020 SHALL drive lamps as follows: in GREEN and YELLOW, only channel active shows green or yellow respectively and all others show red; in ALL_RED and WALK, red is all-ones; exactly one of green/yellow/red SHALL be high per channel at all times.
REQ-021 SHALL register outputs so they change on the cycle after the state transition.
REQ-022 SHALL, when en=0, hold FSM, counters, latches and outputs unchanged; demand and ped_req SHALL NOT be latched while en=0.
REQ-023 SHALL, at NCH not a power of 2, never let active exceed NCH-1.

Reset
REQ-024 SHALL, with reset=1 on a rising CLK edge, force state ALL_RED, ms=0, prescaler=0, latches=0, active=NCH-1, red=all-ones, green=0, yellow=0 and walk=0.
REQ-025 SHALL give reset priority over en and over every other input.
REQ-026 SHALL, on reset asserted mid-GREEN or mid-YELLOW, go straight to all red the next cycle with no yellow.
REQ-027 SHALL, after reset, serve channel 0 first when no demand is latched.

Configuration
REQ-028 SHALL provide macro TRAFFIC_PED_WALK_EN.
REQ-029 SHALL, with TRAFFIC_PED_WALK_EN defined: latch ped_req, clear the latch on WALK entry, and in ALL_RED at ms = ALLRED_MS with the ped latch set enter WALK instead of GREEN; walk=1 only in WALK; after ms = WALK_MS go to ALL_RED; channel selection is deferred to that following ALL_RED.
REQ-030 SHALL, without TRAFFIC_PED_WALK_EN: keep the ports present, ignore ped_req, tie walk to 0 and make WALK unreachable.

Verification
Parameters for all scenarios: NCH=3, PRESC=2, GREEN_MS=10, MIN_GREEN_MS=4, YELLOW_MS=3, ALLRED_MS=2, WALK_MS=5.
REQ-031 SHALL cover: reset, en=1, demand=0 -> ALL_RED for 4 cycles, green[0] for 20, yellow[0] for 6, ALL_RED for 4, then green[1].
REQ-032 SHALL cover: demand[2] pulsed for 1 cycle during green[0] at ms=1 -> yellow[0] at ms=4 (8 cycles into green), then green[2], skipping channel 1.
REQ-033 SHALL cover: en=0 for 50 cycles mid-YELLOW -> outputs and counters frozen; yellow resumes with remaining duration unchanged.
REQ-034 SHALL cover: reset at cycle 10 of green[1] -> next cycle red=3'b111 and green=0; after ALLRED, green[0].
REQ-035 SHALL cover, with TRAFFIC_PED_WALK_EN: ped_req pulse during green[0] -> YELLOW, ALL_RED (4 cycles), walk=1 for 10 cycles with red=3'b111, ALL_RED (4 cycles), then green[1].
REQ-036 SHALL cover, without TRAFFIC_PED_WALK_EN: same stimulus -> walk stays 0 and the sequence is identical to REQ-031.
